// File: rtl/clkdivc_pkg.sv
// clkdivc_pkg: ratio codes and elaboration-time helpers shared by the clkdivc divider
package clkdivc_pkg;
  typedef enum logic [1:0] {DIV_2, DIV_3P5, DIV_4, DIV_BAD} div_e;
  function automatic div_e div_code(input logic [23:0] s);
    return s == "2.0" ? DIV_2 : s == "4.0" ? DIV_4 : s == "3.5" ? DIV_3P5 : DIV_BAD;
  endfunction
  // 3.5 mode counts half-periods, hence 7 phases
  function automatic logic [2:0] div_n(input div_e c);
    return c == DIV_4 ? 3'd4 : c == DIV_3P5 ? 3'd7 : 3'd2;
  endfunction
endpackage

// File: rtl/clkdivc_slip.sv
// clkdivc_slip: ALIGNWD rise detector giving a one-cycle hold pulse; detector resets to 1
module clkdivc_slip
  import clkdivc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic align,
  output logic hold
);
  logic a_q, hold_q, hold_d;
  always_comb hold_d = align & ~a_q;
  always_ff @(posedge clk)
    if (!rst_n) begin
      a_q <= 1'b1;
      hold_q <= 1'b0;
    end else begin
      a_q <= align;
      hold_q <= hold_d;
    end
  assign hold = hold_q;
endmodule

// File: rtl/clkdivc.sv
// clkdivc: CLKDIVC-compatible divider (/2, /4; /3.5 when CLKDIVC_DIV35_EN is defined) with CDIV1 pass-through
module clkdivc
  import clkdivc_pkg::*;
#(
  parameter logic [23:0] DIV = "2.0",
  parameter logic [63:0] GSR = "DISABLED"
) (
  input  logic CLKI,
  input  logic RST_N,
  input  logic ALIGNWD,
  output logic CDIV1,
  output logic CDIVX
);
  localparam div_e CODE = div_code(DIV);
  localparam logic [2:0] N = div_n(CODE);
`ifdef CLKDIVC_DIV35_EN
  localparam bit DIV_OK = CODE != DIV_BAD;
  localparam bit HALF = CODE == DIV_3P5;
`else
  localparam bit DIV_OK = CODE == DIV_2 || CODE == DIV_4;
  localparam bit HALF = 1'b0;
`endif
  localparam bit GSR_OK = GSR == "DISABLED" || GSR == {8'd0, "ENABLED"};
  if (!DIV_OK) begin : g_bad_div
    $fatal(1, "clkdivc: illegal DIV value");
  end
  if (!GSR_OK) begin : g_bad_gsr
    $fatal(1, "clkdivc: illegal GSR value");
  end
  logic hold;
  logic [2:0] cnt_q, cnt_d;
  logic cdivx_q, cdivx_d;
  assign CDIV1 = CLKI;
  clkdivc_slip u_slip (.clk(CLKI), .rst_n(RST_N), .align(ALIGNWD), .hold(hold));
  // In 3.5 mode cnt holds the phase at each rising edge, stepping two half-phases mod 7
  always_comb begin
    cnt_d = hold ? cnt_q
          : HALF ? (cnt_q >= 3'd5 ? cnt_q - 3'd5 : cnt_q + 3'd2)
          : (cnt_q == N - 3'd1 ? 3'd0 : cnt_q + 3'd1);
    cdivx_d = HALF ? cnt_d inside {3'd4, 3'd5} : cnt_d >= (N >> 1);
  end
  always_ff @(posedge CLKI)
    if (!RST_N) begin
      cnt_q <= 3'd0;
      cdivx_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      cdivx_q <= cdivx_d;
    end
`ifdef CLKDIVC_DIV35_EN
  if (HALF) begin : g_half
    logic fh_q, fh_d, fv_q;
    // OR of rise/fall flops each flagging phases 4..5 yields high for phases 4..6; fv_q masks stale fall state across reset
    always_comb fh_d = cnt_q inside {3'd3, 3'd4};
    always_ff @(negedge CLKI) fh_q <= fh_d;
    always_ff @(posedge CLKI) fv_q <= RST_N;
    assign CDIVX = cdivx_q | (fh_q & fv_q);
  end else begin : g_full
    assign CDIVX = cdivx_q;
  end
`else
  assign CDIVX = cdivx_q;
`endif
endmodule

// File: tb/tb_clkdivc.sv
// tb_clkdivc: table-driven check of /2 and /4 divider instances, plus /3.5 when CLKDIVC_DIV35_EN is defined
module tb_clkdivc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic align = 1'b0;
  logic d1_2, dx_2, d1_4, dx_4;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct packed {logic rst_n; logic align; logic e2; logic e4;} vec_t;
  vec_t tv[$];
  always #5 clk = ~clk;
  clkdivc #(.DIV("2.0"), .GSR("DISABLED")) u2 (.CLKI(clk), .RST_N(rst_n), .ALIGNWD(align), .CDIV1(d1_2), .CDIVX(dx_2));
  clkdivc #(.DIV("4.0"), .GSR("DISABLED")) u4 (.CLKI(clk), .RST_N(rst_n), .ALIGNWD(align), .CDIV1(d1_4), .CDIVX(dx_4));
`ifdef CLKDIVC_DIV35_EN
  logic d1_35, dx_35;
  clkdivc #(.DIV("3.5"), .GSR("DISABLED")) u35 (.CLKI(clk), .RST_N(rst_n), .ALIGNWD(align), .CDIV1(d1_35), .CDIVX(dx_35));
`endif
  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask
  task automatic v(input logic [3:0] c);
    tv.push_back(c);
  endtask
  initial begin
    // {rst_n, align} _ {CDIVX /2, CDIVX /4} after each rising edge
    v(4'b00_00); v(4'b00_00);
    v(4'b10_10); v(4'b10_01); v(4'b10_11); v(4'b10_00); v(4'b10_10); v(4'b10_01); v(4'b10_11); v(4'b10_00);
    v(4'b10_10); v(4'b10_01); v(4'b10_11); v(4'b11_00); v(4'b11_00); v(4'b11_10); v(4'b11_01);
    v(4'b11_11); v(4'b11_00); v(4'b11_10); v(4'b11_01); v(4'b11_11); v(4'b11_00);
    v(4'b11_10); v(4'b11_01); v(4'b01_00); v(4'b01_00);
    v(4'b11_10); v(4'b11_01); v(4'b11_11); v(4'b11_00); v(4'b11_10); v(4'b11_01); v(4'b11_11); v(4'b11_00);
    v(4'b10_10); v(4'b11_01); v(4'b11_01); v(4'b11_11); v(4'b11_00);
    v(4'b10_10); v(4'b01_00); v(4'b11_10); v(4'b11_01);
    foreach (tv[i]) begin
      rst_n = tv[i].rst_n;
      align = tv[i].align;
      @(posedge clk);
      #1;
      chk($sformatf("div2 row %0d", i), dx_2, tv[i].e2);
      chk($sformatf("div4 row %0d", i), dx_4, tv[i].e4);
      chk($sformatf("cdiv1 high row %0d", i), d1_2, 1'b1);
      @(negedge clk);
      #1;
      chk($sformatf("cdiv1 low row %0d", i), d1_4, 1'b0);
    end
`ifdef CLKDIVC_DIV35_EN
    rst_n = 1'b0;
    align = 1'b0;
    @(posedge clk);
    #1;
    chk("div35 reset", dx_35, 1'b0);
    for (int k = 0; k < 140; k++) begin
      @(clk);
      #1;
      chk($sformatf("div35 half %0d", k), dx_35, (k % 7) inside {3, 4, 5});
      if (k == 0) rst_n = 1'b1;
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
